// File: rtl/nn_pkg.sv
// ============================================================================
// nn_pkg : shared word sizes and the 3x3 tap-offset decode.
// Rev 1.0
// ============================================================================
`default_nettype none

package nn_pkg;

    localparam int DATSIZE = 22;
    localparam int PARSIZE = 16;
    localparam int FPSHIFT = 8;

    typedef struct packed {
        logic signed [1:0] dy;
        logic signed [1:0] dx;
    } tap_off_t;

    // Row-major 3x3 code; codes beyond 8 collapse onto the centre tap.
    function automatic tap_off_t tap_offset(input logic [3:0] s);
        tap_off_t o;
        o.dy = 2'sd0;
        o.dx = 2'sd0;
        case (s)
            4'd0: begin o.dy = -2'sd1; o.dx = -2'sd1; end
            4'd1: begin o.dy = -2'sd1; o.dx =  2'sd0; end
            4'd2: begin o.dy = -2'sd1; o.dx =  2'sd1; end
            4'd3: begin o.dy =  2'sd0; o.dx = -2'sd1; end
            4'd5: begin o.dy =  2'sd0; o.dx =  2'sd1; end
            4'd6: begin o.dy =  2'sd1; o.dx = -2'sd1; end
            4'd7: begin o.dy =  2'sd1; o.dx =  2'sd0; end
            4'd8: begin o.dy =  2'sd1; o.dx =  2'sd1; end
            default: begin o.dy = 2'sd0; o.dx = 2'sd0; end
        endcase
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/feat_buf_bank.sv
// ============================================================================
// feat_buf_bank : simple dual-port RAM, one write port, registered read port.
// Rev 1.0
// ============================================================================
`default_nettype none

module feat_buf_bank #(
    parameter int DATSIZE = 22,
    parameter int ADDR_W  = 12
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [DATSIZE-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [DATSIZE-1:0] rdata
);

    logic [DATSIZE-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

`default_nettype wire

// File: rtl/feat_buf_pingpong.sv
// ============================================================================
// feat_buf_pingpong : two-bank feature-map buffer, producer fills one bank
// while the consumer reads 3x3 taps from the other. Rev 1.0
// ============================================================================
`default_nettype none

module feat_buf_pingpong
    import nn_pkg::*;
#(
    parameter int DATSIZE = 22,
    parameter int ADDR_W  = 12,
    parameter int LOG_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_load,
    input  logic [LOG_W-1:0]          cfg_lh,
    input  logic [LOG_W-1:0]          cfg_lw,
    input  logic [LOG_W-1:0]          cfg_lc,
    output logic                      cfg_err,
    input  logic                      wr_valid,
    input  logic [DATSIZE-1:0]        wr_data,
    output logic                      wr_ready,
    output logic                      wr_done,
    output logic                      rd_avail,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_y,
    input  logic [ADDR_W-1:0]         rd_x,
    input  logic [ADDR_W-1:0]         rd_c,
    input  logic [3:0]                rd_s,
    output logic                      rd_valid,
    output logic signed [DATSIZE-1:0] rd_data,
    input  logic                      rd_release
);

    localparam int SUM_W = LOG_W + 2;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]         r_full;
    logic               r_wbank;
    logic               r_rbank;
    logic [ADDR_W-1:0]  r_wcnt;
    logic [LOG_W-1:0]   r_lh, r_lw, r_lc;
    logic               r_cfg_err, r_wr_done;
    logic               r_rd_valid, r_inb, r_avail, r_rsel;

    logic [SUM_W-1:0]   w_cfg_sum, w_shape_sum, w_hw_sum;
    logic               w_cfg_ok, w_wr_fire, w_last, w_rel;
    logic [1:0]         w_full_nxt;
    tap_off_t           w_off;
    logic [ADDR_W:0]    w_ty, w_tx;
    logic               w_inb;
    logic [ADDR_W-1:0]  w_raddr;
    logic [DATSIZE-1:0] w_q [2];

    assign w_cfg_sum   = SUM_W'(cfg_lh) + SUM_W'(cfg_lw) + SUM_W'(cfg_lc);
    assign w_shape_sum = SUM_W'(r_lh) + SUM_W'(r_lw) + SUM_W'(r_lc);
    assign w_hw_sum    = SUM_W'(r_lh) + SUM_W'(r_lw);
    assign w_cfg_ok    = (r_full == 2'b00) && (r_wcnt == '0) && (int'(w_cfg_sum) <= ADDR_W);

    assign wr_ready  = !r_full[r_wbank];
    assign rd_avail  = r_full[r_rbank];
    assign w_wr_fire = wr_valid && wr_ready;
    assign w_last    = ({1'b0, r_wcnt} == ((ONE << w_shape_sum) - ONE));
    assign w_rel     = rd_release && rd_avail;

    // A final write and a release never touch the same bank: one needs it empty, the other full.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_fire && w_last) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
        if (w_rel) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full     <= 2'b00;
            r_wbank    <= 1'b0;
            r_rbank    <= 1'b0;
            r_wcnt     <= '0;
            r_lh       <= '0;
            r_lw       <= '0;
            r_lc       <= '0;
            r_cfg_err  <= 1'b0;
            r_wr_done  <= 1'b0;
        end else begin
            r_cfg_err <= cfg_load && !w_cfg_ok;
            if (cfg_load && w_cfg_ok) begin
                r_lh <= cfg_lh;
                r_lw <= cfg_lw;
                r_lc <= cfg_lc;
            end
            r_wr_done <= w_wr_fire && w_last;
            r_full    <= w_full_nxt;
            if (w_wr_fire) begin
                if (w_last) begin
                    r_wcnt  <= '0;
                    r_wbank <= ~r_wbank;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
            if (w_rel) begin
                r_rbank <= ~r_rbank;
            end
        end
    end

    // Tap coordinates are one bit wider than the address so that -1 shows up in the MSB.
    assign w_off   = tap_offset(rd_s);
    assign w_ty    = {1'b0, rd_y} + {{(ADDR_W-1){w_off.dy[1]}}, w_off.dy};
    assign w_tx    = {1'b0, rd_x} + {{(ADDR_W-1){w_off.dx[1]}}, w_off.dx};
    assign w_inb   = !w_ty[ADDR_W] && !w_tx[ADDR_W] &&
                     (w_ty < (ONE << r_lh)) && (w_tx < (ONE << r_lw));
    assign w_raddr = (rd_c << w_hw_sum) | (w_ty[ADDR_W-1:0] << r_lw) | w_tx[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_inb      <= 1'b0;
            r_avail    <= 1'b0;
            r_rsel     <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_inb      <= w_inb;
            r_avail    <= rd_avail;
            r_rsel     <= r_rbank;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        feat_buf_bank #(
            .DATSIZE (DATSIZE),
            .ADDR_W  (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .we    (w_wr_fire && (r_wbank == 1'(b))),
            .waddr (r_wcnt),
            .wdata (wr_data),
            .raddr (w_raddr),
            .rdata (w_q[b])
        );
    end

    assign cfg_err  = r_cfg_err;
    assign wr_done  = r_wr_done;
    assign rd_valid = r_rd_valid;
    assign rd_data  = (r_inb && r_avail) ? w_q[r_rsel] : '0;

endmodule

`default_nettype wire

// File: tb/tb_feat_buf_pingpong.sv
// ============================================================================
// tb_feat_buf_pingpong : directed self-checking bench for feat_buf_pingpong.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_feat_buf_pingpong;

    localparam int DW = 22;
    localparam int AW = 12;
    localparam int LW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_load;
    logic [LW-1:0]     cfg_lh, cfg_lw, cfg_lc;
    logic              cfg_err;
    logic              wr_valid;
    logic [DW-1:0]     wr_data;
    logic              wr_ready, wr_done, rd_avail;
    logic              rd_en;
    logic [AW-1:0]     rd_y, rd_x, rd_c;
    logic [3:0]        rd_s;
    logic              rd_valid;
    logic signed [DW-1:0] rd_data;
    logic              rd_release;

    int n_tests = 0;
    int n_fail  = 0;

    feat_buf_pingpong #(.DATSIZE(DW), .ADDR_W(AW), .LOG_W(LW)) dut (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load), .cfg_lh(cfg_lh), .cfg_lw(cfg_lw), .cfg_lc(cfg_lc),
        .cfg_err(cfg_err),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
        .rd_avail(rd_avail), .rd_en(rd_en), .rd_y(rd_y), .rd_x(rd_x), .rd_c(rd_c),
        .rd_s(rd_s), .rd_valid(rd_valid), .rd_data(rd_data), .rd_release(rd_release)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int lh, input int lw, input int lc);
        cfg_load = 1'b1;
        cfg_lh = LW'(lh); cfg_lw = LW'(lw); cfg_lc = LW'(lc);
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic wr(input int d);
        wr_valid = 1'b1;
        wr_data  = DW'(d);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input int y, input int x, input int s);
        rd_en = 1'b1;
        rd_y = AW'(y); rd_x = AW'(x); rd_c = '0; rd_s = 4'(s);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_lh = '0; cfg_lw = '0; cfg_lc = '0;
        wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_y = '0; rd_x = '0;
        rd_c = '0; rd_s = '0; rd_release = 1'b0;
        tick(); tick();
        check("rst_wr_ready", int'(wr_ready), 1);
        check("rst_rd_avail", int'(rd_avail), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data",  int'(rd_data), 0);
        check("rst_wr_done",  int'(wr_done), 0);
        check("rst_cfg_err",  int'(cfg_err), 0);
        rst = 1'b0;
        tick();

        // 2x2x1 map, values 1..4 in raster order
        cfg(1, 1, 0);
        check("cfg_ok_no_err", int'(cfg_err), 0);
        wr(1); wr(2); wr(3);
        check("done_not_early", int'(wr_done), 0);
        wr(4);
        check("done_after_4", int'(wr_done), 1);
        check("avail_after_fill", int'(rd_avail), 1);
        check("ready_bank1_free", int'(wr_ready), 1);
        rd(1, 1, 4);
        check("rd_valid_centre", int'(rd_valid), 1);
        check("rd_centre_11", int'(rd_data), 4);
        check("rd_valid_drop", int'(rd_valid), 1);
        tick();
        check("rd_valid_low", int'(rd_valid), 0);
        rd(0, 0, 0);
        check("oob_neg_data", int'(rd_data), 0);
        check("oob_neg_valid", int'(rd_valid), 1);
        rd(1, 1, 8);
        check("oob_pos_data", int'(rd_data), 0);
        rd(0, 0, 8);
        check("tap8_from_00", int'(rd_data), 4);
        rd(1, 0, 1);
        check("tap1_from_10", int'(rd_data), 1);
        rd(0, 1, 12);
        check("tap_code12_centre", int'(rd_data), 2);

        // second bank fills while the first is still held
        wr(10); wr(11); wr(12); wr(13);
        check("done_bank1", int'(wr_done), 1);
        check("ready_both_full", int'(wr_ready), 0);
        release_bank();
        check("avail_after_rel", int'(rd_avail), 1);
        check("ready_after_rel", int'(wr_ready), 1);
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_c = '0; rd_s = 4'd4;
            rd_y = AW'(i / 2); rd_x = AW'(i % 2);
            tick();
            check("b2b_valid", int'(rd_valid), 1);
            check("b2b_data", int'(rd_data), 10 + i);
        end
        rd_en = 1'b0;

        // final write to bank1 coincides with the release of bank0
        release_bank();
        check("avail_all_empty", int'(rd_avail), 0);
        wr(20); wr(21); wr(22); wr(23);
        wr(30); wr(31); wr(32);
        rd_release = 1'b1;
        wr(33);
        rd_release = 1'b0;
        check("coinc_done", int'(wr_done), 1);
        check("coinc_ready", int'(wr_ready), 1);
        check("coinc_avail", int'(rd_avail), 1);
        rd(0, 0, 4);
        check("coinc_rbank1", int'(rd_data), 30);
        release_bank();
        check("coinc_empty", int'(rd_avail), 0);

        // oversize shape rejected, old 2x2x1 shape kept
        cfg(3, 3, 7);
        check("cfg_too_big_err", int'(cfg_err), 1);
        tick();
        check("cfg_err_pulse", int'(cfg_err), 0);
        wr(40); wr(41); wr(42);
        check("shape_kept_3", int'(wr_done), 0);
        wr(43);
        check("shape_kept_4", int'(wr_done), 1);
        release_bank();
        wr(44);
        cfg(0, 0, 0);
        check("cfg_midfill_err", int'(cfg_err), 1);
        wr(45); wr(46);
        check("midfill_shape_3", int'(wr_done), 0);
        wr(47);
        check("midfill_shape_4", int'(wr_done), 1);

        // reset in the middle of a fill
        wr(60); wr(61);
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(wr_ready), 1);
        check("midrst_avail", int'(rd_avail), 0);
        tick();
        rst = 1'b0;
        tick();
        cfg(1, 1, 0);
        check("postrst_cfg_ok", int'(cfg_err), 0);
        wr(50); wr(51); wr(52);
        check("postrst_not_done", int'(wr_done), 0);
        wr(53);
        check("postrst_done", int'(wr_done), 1);
        rd(1, 0, 4);
        check("postrst_read", int'(rd_data), 52);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/feat_buf_pingpong.md
FEAT_BUF_PINGPONG -- requirements
Module: feat_buf_pingpong

Interface
REQ-001 SHALL have parameter DATSIZE, default 22, the feature word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 12, the log2 of the words per bank.
REQ-003 SHALL have parameter LOG_W, default 3, the width of each log2 dimension field.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, named as below.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- cfg_load  in  1  latch the layer shape.
- cfg_lh, cfg_lw, cfg_lc  in  LOG_W each  log2 of height, width, channels.
- cfg_err  out  1  one-cycle pulse: cfg_load was rejected.
- wr_valid  in  1  producer word valid.
- wr_data  in  DATSIZE  producer word.
- wr_ready  out  1  a write bank is free.
- wr_done  out  1  one-cycle pulse: a bank is filled.
- rd_avail  out  1  the read bank holds a full map.
- rd_en  in  1  read request.
- rd_y, rd_x, rd_c  in  ADDR_W each  centre coordinate.
- rd_s  in  4  tap code: 0..8 is row-major in 3x3, 4 is the centre.
- rd_valid  out  1  read data valid.
- rd_data  out  DATSIZE signed  tap value.
- rd_release  in  1  consumer is finished with the read bank.

Function
REQ-006 SHALL hold two banks (0 and 1), each of depth 2^ADDR_W.
REQ-007 SHALL track three state items: full[1:0], wbank and rbank.
REQ-008 SHALL accept cfg_load only when full==2'b00 and the write counter is 0; otherwise it SHALL ignore cfg_load and pulse cfg_err the next cycle.
REQ-009 SHALL treat a shape with cfg_lh+cfg_lw+cfg_lc > ADDR_W as rejected (cfg_err pulse).
REQ-010 SHALL drive wr_ready = !full[wbank].
- A word SHALL be written on wr_valid && wr_ready.
- The write goes to bank wbank at address wcnt, where wcnt is a raster counter (x fastest, then y, then c).
REQ-011 On the write with wcnt == 2^(lh+lw+lc)-1, the block SHALL:
- set full[wbank],
- toggle wbank,
- reset wcnt to 0,
- pulse wr_done the next cycle.
REQ-012 SHALL drive rd_avail = full[rbank].
- rd_release while rd_avail SHALL clear full[rbank] and toggle rbank.
- rd_release while !rd_avail SHALL be ignored.
REQ-013 SHALL apply both updates when the final write and rd_release occur in the same cycle. wr_ready SHALL rise the next cycle if the released bank equals the new wbank.
REQ-014 SHALL map the tap code to offsets: dy = rd_s/3 - 1 and dx = rd_s%3 - 1. Codes 9..15 SHALL give dy = dx = 0.
REQ-015 SHALL compute ty = rd_y+dy and tx = rd_x+dx signed, one bit wider than ADDR_W.
- A tap is in bounds when 0 <= ty < 2^lh and 0 <= tx < 2^lw.
- Its address SHALL be (rd_c << (lh+lw)) | (ty << lw) | tx.
REQ-016 SHALL have read latency exactly 1.
- rd_valid SHALL equal rd_en registered.
- rd_data SHALL be the bank word when the registered in-bounds flag and the registered rd_avail are both 1, else 0.
REQ-017 SHALL never read from the bank being written, because reads always target rbank.
REQ-018 SHALL allow back-to-back rd_en every cycle, with no bubbles.

Reset
REQ-019 On rst, the block SHALL set full=0, wbank=0, rbank=0, wcnt=0 and shape=(0,0,0).
REQ-020 On rst, all outputs SHALL be 0 except wr_ready, which SHALL be 1.
REQ-021 RAM contents SHALL NOT be reset.
REQ-022 Reset asserted mid-fill SHALL discard the partial fill.

Structure
REQ-023 SHALL place DATSIZE, PARSIZE, FPSHIFT and the tap-offset decode function in shared package nn_pkg.
REQ-024 SHALL instantiate sub-module feat_buf_bank twice.
- feat_buf_bank is an inferred simple dual-port RAM: one write port, one registered read port, latency 1.
- The 2-way mux on rbank SHALL use the registered bank select.

Verification
REQ-025 Config 2x2x1, write 1,2,3,4 -> wr_done pulses after the 4th write, rd_avail=1; read (y1,x1,c0,s4) -> 4 the next cycle.
REQ-026 Same data, read (y0,x0,s0) and (y1,x1,s8) -> rd_data=0, rd_valid=1; read (y0,x0,s8) -> 4.
REQ-027 Fill bank0, then fill bank1 with 10..13 -> wr_ready=0 after both fills; rd_release -> rd_avail stays 1, and reads return 10..13; wr_ready=1.
REQ-028 Final write to bank1 and rd_release of bank0 in the same cycle -> the next cycle has full=2'b10, wr_ready=1, rbank=1.
REQ-029 cfg_load with lh=3, lw=3, lc=7 (sum 13 > 12), or any cfg_load after one write -> cfg_err pulse, shape unchanged.
REQ-030 Assert rst after 2 of 4 writes -> wr_ready=1, rd_avail=0; 4 fresh writes -> wr_done pulses after the 4th.
